// File: rtl/msk_and_hpc2_stream_if.sv
// msk_and_hpc2_stream_if: handshake bundle for the masked HPC2 AND stream
// in_a/in_b/out_c: d shares of W bits, share j at [j*W +: W]
// in_rnd: one W-bit mask per share pair (i<j), lexicographic order
// in_valid/in_ready, rnd_valid/rnd_ready, out_valid/out_ready: handshakes
interface msk_and_hpc2_stream_if #(parameter int d = 2, parameter int W = 1);
  logic [d*W-1:0] in_a, in_b;
  logic [W*d*(d-1)/2-1:0] in_rnd;
  logic in_valid, in_ready, rnd_valid, rnd_ready;
  logic [d*W-1:0] out_c;
  logic out_valid, out_ready;
  modport master(
    output in_a, in_b, in_valid, in_rnd, rnd_valid, out_ready,
    input in_ready, rnd_ready, out_c, out_valid
  );
  modport slave(
    input in_a, in_b, in_valid, in_rnd, rnd_valid, out_ready,
    output in_ready, rnd_ready, out_c, out_valid
  );
endinterface

// File: rtl/msk_and_hpc2_stream.sv
// msk_and_hpc2_stream: two-stage HPC2 masked AND gadget with valid/ready streaming
// clk: rising-edge clock; rst_n: asynchronous active-low reset
// s: slave side of msk_and_hpc2_stream_if (operands, randomness, shared result)
module msk_and_hpc2_stream #(
  parameter int d = 2,
  parameter int W = 1
) (
  input logic clk,
  input logic rst_n,
  msk_and_hpc2_stream_if.slave s
);
  logic s1_valid, s1_free, s2_free, fire, adv;
  logic [W-1:0] rij;
  logic [W-1:0] na [d];
  logic [W-1:0] ab_n [d];
  logic [W-1:0] ra [d];
  logic [W-1:0] rab [d];
  logic [W-1:0] u_n [d][d];
  logic [W-1:0] v_n [d][d];
  logic [W-1:0] ru [d][d];
  logic [W-1:0] rv [d][d];
  logic [d*W-1:0] c_n;
  assign s2_free = !s.out_valid || s.out_ready;
  assign s1_free = !s1_valid || s2_free;
  assign fire = s.in_valid && s.rnd_valid && s1_free;
  assign adv = s1_valid && s2_free;
  assign s.in_ready = s1_free && s.rnd_valid;
  assign s.rnd_ready = s1_free && s.in_valid;
  // inversion kept in its own instance so it cannot fold into the AND with r_ij
  for (genvar i = 0; i < d; i++) begin : g_not
    bin_NOT #(.W(W)) u_not (.a(s.in_a[i*W +: W]), .y(na[i]));
  end
  // diagonal cross terms stay zero so the output XOR can run over all j
  always_comb begin
    rij = '0;
    for (int i = 0; i < d; i++) begin
      ab_n[i] = s.in_a[i*W +: W] & s.in_b[i*W +: W];
      for (int j = 0; j < d; j++) begin
        u_n[i][j] = '0;
        v_n[i][j] = '0;
      end
    end
    for (int i = 0; i < d; i++)
      for (int j = i + 1; j < d; j++) begin
        rij = s.in_rnd[(i*d - i*(i+1)/2 + j - i - 1)*W +: W];
        u_n[i][j] = na[i] & rij;
        v_n[i][j] = s.in_b[j*W +: W] ^ rij;
        u_n[j][i] = na[j] & rij;
        v_n[j][i] = s.in_b[i*W +: W] ^ rij;
      end
  end
  always_comb begin
    c_n = '0;
    for (int i = 0; i < d; i++) begin
      c_n[i*W +: W] = rab[i];
      for (int j = 0; j < d; j++)
        c_n[i*W +: W] = c_n[i*W +: W] ^ ru[i][j] ^ (ra[i] & rv[i][j]);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s.out_valid <= 1'b0;
      s.out_c <= '0;
      for (int i = 0; i < d; i++) begin
        ra[i] <= '0;
        rab[i] <= '0;
        for (int j = 0; j < d; j++) begin
          ru[i][j] <= '0;
          rv[i][j] <= '0;
        end
      end
    end else begin
      if (fire)
        for (int i = 0; i < d; i++) begin
          ra[i] <= s.in_a[i*W +: W];
          rab[i] <= ab_n[i];
          for (int j = 0; j < d; j++) begin
            ru[i][j] <= u_n[i][j];
            rv[i][j] <= v_n[i][j];
          end
        end
      if (adv) s.out_c <= c_n;
      s1_valid <= fire || (s1_valid && !s2_free);
      s.out_valid <= adv || (s.out_valid && !s.out_ready);
    end
endmodule

module bin_NOT #(parameter int W = 1) (
  input logic [W-1:0] a,
  output logic [W-1:0] y
);
  assign y = ~a;
endmodule
